ks_addsub_pipe: RTL and testbench
=================================

// Module: ks_addsub_pipe
// PURPOSE
//  Pipelined 16-bit Kogge-Stone adder/subtractor with valid/ready flow control.
//  Complements the combinational prefix layers: it adds operand conditioning (B
//  inversion, carry-in) and pipeline registers, and closes the sum/flags path.
//  It is the arithmetic front end used by the datapath wherever a registered
//  add or subtract result is consumed through a handshake.
// PARAMETERS
//  WIDTH   16  operand width; must be a power of two (prefix depth = log2(WIDTH) = 4)
//  SPLIT    2  prefix layers between pipeline registers (1, 2 or 4)
// PORTS
//  clk        in   1      clock, rising edge
//  rst        in   1      asynchronous, active-high reset
//  in_valid   in   1      operand beat valid
//  in_ready   out  1      unit can accept a beat this cycle
//  in_a       in   WIDTH  operand A
//  in_b       in   WIDTH  operand B
//  in_sub     in   1      1: A-B, 0: A+B
//  out_valid  out  1      result beat valid
//  out_ready  in   1      downstream accepts the result
//  out_sum    out  WIDTH  A+B or A-B, modulo 2^WIDTH
//  out_cout   out  1      carry out of the MSB (for sub: 1 = no borrow)
//  out_ovf    out  1      signed two's-complement overflow
//  out_zero   out  1      out_sum == 0
// BEHAVIOUR
//  - Transfers: input on in_valid&in_ready; output on out_valid&out_ready, both at posedge clk.
//  - Stage 0 (registered): Bx = in_sub ? ~in_b : in_b; cin = in_sub.
//    P = A^Bx; G = A&Bx; G[0] |= P[0]&cin. Also latch P, A[MSB], Bx[MSB] for the sum and flags.
//  - Prefix layers k = 0..3 use distance d = 2^k. For i >= d:
//    G'[i] = G[i] | P[i]&G[i-d]; P'[i] = P[i]&P[i-d]. For i < d, bits pass through.
//    Registers after every SPLIT layers, so SPLIT=2 gives 2 prefix stages.
//  - Final stage (combinational into the output register):
//    C[-1] = cin; C[i] = G*[i]; sum[i] = P0[i]^C[i-1].
//    cout = C[W-1]; ovf = (A[MSB]==Bx[MSB]) & (sum[MSB]!=A[MSB]); zero = ~|sum.
//  - Latency: 1 + (log2(WIDTH)/SPLIT) cycles from input transfer to out_valid.
//    This is 3 cycles at the defaults.
//  - Throughput: 1 beat/cycle when out_ready is held high. Each stage has a valid bit.
//    A stage loads when it is empty or when its content moves on in the same cycle.
//    in_ready = ~v0 | (stage 0 advances). No combinational path from in_valid to in_ready.
//    The path out_ready->in_ready is permitted.
//  - Backpressure: with out_ready=0 the pipe fills, then in_ready=0. Stalled stages hold
//    data and flags bit-exact. No beat is dropped or duplicated, and order is preserved.
//  - Bubbles: a gap in in_valid propagates as an invalid stage. Data in invalid stages is
//    don't-care but must not affect the flags of valid beats.
//  - Reset (async assert; synchronous-style release is fine):
//    all stage valid bits = 0; out_valid = 0; out_sum = 0; out_cout = out_ovf = out_zero = 0;
//    in_ready = 1 from the first cycle after release.
//    Reset mid-operation discards every in-flight beat.
//  - Wrap-around: results are modulo 2^WIDTH. 0xFFFF+1 -> sum 0x0000, cout 1, zero 1.
//  - An input beat and an output beat may transfer in the same cycle on a full pipe.
//    The pipe then stays full.
// STRUCTURE
//  - Shared package ks_pkg: KS_WIDTH=16, KS_DEPTH=$clog2(KS_WIDTH), typedef ks_word_t
//    (logic [KS_WIDTH-1:0]), and struct ks_pg_t {P, G, P0, a_msb, b_msb, cin}.
//  - One sub-module, ks_prefix_layer #(WIDTH, DIST): purely combinational single Kogge-Stone
//    layer (P,G in -> P',G' out). It is instantiated KS_DEPTH times via generate, with
//    pipeline registers inserted between groups of SPLIT layers.
//  - Top level holds operand prep, stage registers, the valid/ready chain, and sum/flag logic.
// TESTING
//  1. Add: A=0x1234, B=0x4321, sub=0 -> sum 0x5555, cout 0, ovf 0, zero 0.
//     out_valid exactly 3 cycles after the accept.
//  2. Sub/borrow: A=0x0005, B=0x0007, sub=1 -> sum 0xFFFE, cout 0 (borrow), ovf 0.
//     Then A=7, B=5 -> 0x0002, cout 1.
//  3. Wrap/ovf: 0xFFFF+0x0001 -> 0x0000, cout 1, zero 1, ovf 0.
//     0x7FFF+0x0001 -> 0x8000, ovf 1. 0x8000-0x0001 -> 0x7FFF, ovf 1.
//  4. Backpressure: stream 6 beats with out_ready=0 -> in_ready drops after 3 accepts.
//     Raise out_ready -> all 6 results emerge in order with no gaps.
//  5. Reset mid-flight: 2 beats in flight, assert rst -> out_valid 0 immediately.
//     After release, no stale beat ever appears.
//  6. Random: 10k beats with random valid/ready against a golden (a ± b) model.
//     Check data/flags, order, and the beat count.

Source files
------------

// File: rtl/ks_pkg.sv
// Shared types and helpers for the Kogge-Stone adder/subtractor pipeline.
package ks_pkg;

  localparam int KS_WIDTH = 16;
  localparam int KS_DEPTH = $clog2(KS_WIDTH);

  typedef logic [KS_WIDTH-1:0] ks_word_t;

  // Everything a beat carries down the pipe: the evolving prefix pair (p, g),
  // the original bit propagates p0 for the final XOR, and the sign bits and
  // carry-in needed for the sum and overflow flag.
  typedef struct packed {
    ks_word_t p;
    ks_word_t g;
    ks_word_t p0;
    logic     a_msb;
    logic     b_msb;
    logic     cin;
  } ks_pg_t;

  // Operand conditioning: subtraction is A + ~B + 1, with the +1 folded into
  // the bit-0 generate so the prefix tree already sees the carry-in.
  function automatic ks_pg_t ks_prep(input ks_word_t a, input ks_word_t b,
                                     input logic sub);
    ks_word_t bx;
    ks_pg_t   r;
    bx      = sub ? ~b : b;
    r.p     = a ^ bx;
    r.g     = a & bx;
    r.g[0]  = r.g[0] | (r.p[0] & sub);
    r.p0    = r.p;
    r.a_msb = a[KS_WIDTH-1];
    r.b_msb = bx[KS_WIDTH-1];
    r.cin   = sub;
    return r;
  endfunction

endpackage

// File: rtl/ks_prefix_layer.sv
// One combinational Kogge-Stone layer: each bit merges with the bit DIST below.
module ks_prefix_layer #(
  parameter int WIDTH = 16,
  parameter int DIST  = 1
) (
  input  logic [WIDTH-1:0] p_in,
  input  logic [WIDTH-1:0] g_in,
  output logic [WIDTH-1:0] p_out,
  output logic [WIDTH-1:0] g_out
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    if (i >= DIST) begin : g_merge
      assign g_out[i] = g_in[i] | (p_in[i] & g_in[i-DIST]);
      assign p_out[i] = p_in[i] & p_in[i-DIST];
    end else begin : g_pass
      // Bits below DIST already hold their final group terms.
      assign g_out[i] = g_in[i];
      assign p_out[i] = p_in[i];
    end
  end

endmodule

// File: rtl/ks_addsub_pipe.sv
// Pipelined Kogge-Stone add/subtract with valid/ready flow control.
// Register stages: stage 0 (conditioned operands), one stage after each group
// of SPLIT prefix layers except the last, and the output register, which
// captures the last group plus the sum/flag logic.
module ks_addsub_pipe
  import ks_pkg::*;
#(
  parameter int WIDTH = KS_WIDTH,
  parameter int SPLIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero
);

  localparam int DEPTH = $clog2(WIDTH);
  localparam int NGRP  = DEPTH / SPLIT;
  localparam int MSB   = WIDTH - 1;

  // Stage s holds the beat entering prefix group s.
  ks_pg_t          st   [NGRP];
  logic [NGRP-1:0] v;
  logic [NGRP-1:0] rdy;
  logic            rdy_out;

  // Result of each prefix group, before its register.
  ks_word_t grp_p [NGRP];
  ks_word_t grp_g [NGRP];

  ks_pg_t   prep;
  ks_word_t fin_g;
  ks_word_t carry;
  ks_word_t sum;

  assign prep = ks_prep(in_a, in_b, in_sub);

  // Prefix tree: the first layer of every group reads its stage register,
  // the rest chain combinationally from the previous layer.
  for (genvar k = 0; k < DEPTH; k++) begin : g_layer
    ks_word_t p_in, g_in, p_out, g_out;

    if (k % SPLIT == 0) begin : g_head
      assign p_in = st[k/SPLIT].p;
      assign g_in = st[k/SPLIT].g;
    end else begin : g_chain
      assign p_in = g_layer[k-1].p_out;
      assign g_in = g_layer[k-1].g_out;
    end

    ks_prefix_layer #(
      .WIDTH (KS_WIDTH),
      .DIST  (1 << k)
    ) u_layer (
      .p_in  (p_in),
      .g_in  (g_in),
      .p_out (p_out),
      .g_out (g_out)
    );
  end

  for (genvar gi = 0; gi < NGRP; gi++) begin : g_grp
    assign grp_p[gi] = g_layer[(gi+1)*SPLIT-1].p_out;
    assign grp_g[gi] = g_layer[(gi+1)*SPLIT-1].g_out;
  end

  // A stage may load when it, or every valid stage downstream of it, moves on.
  // NOTE: every always_comb output gets a value before any condition, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    rdy_out = ~out_valid | out_ready;
    for (int s = 0; s < NGRP; s++) begin
      rdy[s] = rdy_out;
      for (int j = s; j < NGRP; j++) begin
        rdy[s] = rdy[s] | ~v[j];
      end
    end
  end

  assign in_ready = rdy[0];

  // Valid bits advance with their stage; a bubble shifts in as a 0.
  // NOTE: state is updated with non-blocking assignments so every stage sees
  // its upstream neighbour's value from before this clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v <= '0;
    end else begin
      if (rdy[0]) v[0] <= in_valid;
      for (int s = 1; s < NGRP; s++) begin
        if (rdy[s]) v[s] <= v[s-1];
      end
    end
  end

  // Stage data follows its valid bit and only loads when a real beat arrives.
  // NOTE: the data registers have no reset; the valid bits alone decide
  // whether their contents mean anything, so clearing them buys nothing.
  always_ff @(posedge clk) begin
    if (rdy[0] && in_valid) st[0] <= prep;
    for (int s = 1; s < NGRP; s++) begin
      if (rdy[s] && v[s-1]) begin
        st[s] <= '{p:     grp_p[s-1],
                   g:     grp_g[s-1],
                   p0:    st[s-1].p0,
                   a_msb: st[s-1].a_msb,
                   b_msb: st[s-1].b_msb,
                   cin:   st[s-1].cin};
      end
    end
  end

  // Carry into bit i is the group generate of bits i-1..0 (with cin folded in).
  assign fin_g = grp_g[NGRP-1];
  assign carry = {fin_g[KS_WIDTH-2:0], st[NGRP-1].cin};
  assign sum   = st[NGRP-1].p0 ^ carry;

  // Output register: captures the finished sum and flags of a valid beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
      out_ovf   <= 1'b0;
      out_zero  <= 1'b0;
    end else if (rdy_out) begin
      out_valid <= v[NGRP-1];
      if (v[NGRP-1]) begin
        out_sum  <= sum;
        out_cout <= fin_g[MSB];
        out_ovf  <= (st[NGRP-1].a_msb == st[NGRP-1].b_msb) &
                    (sum[MSB] != st[NGRP-1].a_msb);
        out_zero <= ~|sum;
      end
    end
  end

endmodule

// File: tb/tb_ks_addsub_pipe.sv
// Scoreboard bench for ks_addsub_pipe: the driver pushes the expected result
// when a beat is accepted, the monitor pops and compares on every output beat.
module tb_ks_addsub_pipe;
  import ks_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        in_sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_sum;
  logic        out_cout;
  logic        out_ovf;
  logic        out_zero;

  ks_addsub_pipe #(.WIDTH(16), .SPLIT(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf),
    .out_zero  (out_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
    logic        chk_lat;
    int          acc_cyc;
  } exp_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    exp_t        e;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[12];

  int   checks    = 0;
  int   errors    = 0;
  int   cyc       = 0;
  int   tx        = 0;
  int   rx        = 0;
  int   rdy_mode  = 0;
  logic chk_gap   = 1'b0;
  int   rx_window = 0;
  int   last_arr  = 0;
  exp_t me;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic exp_t mk(input logic [15:0] sum, input logic cout,
                              input logic ovf, input logic zero);
    exp_t e;
    e.sum = sum; e.cout = cout; e.ovf = ovf; e.zero = zero;
    e.chk_lat = 1'b0; e.acc_cyc = 0;
    return e;
  endfunction

  // Golden model in plain arithmetic: subtraction via a 17-bit difference,
  // where the borrow appears in bit 16 and cout is its complement.
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                 input logic sub);
    logic [16:0] r;
    logic        o;
    if (sub) begin
      r = {1'b0, a} - {1'b0, b};
      o = (a[15] != b[15]) && (r[15] != a[15]);
      return mk(r[15:0], ~r[16], o, r[15:0] == 16'h0);
    end
    r = {1'b0, a} + {1'b0, b};
    o = (a[15] == b[15]) && (r[15] != a[15]);
    return mk(r[15:0], r[16], o, r[15:0] == 16'h0);
  endfunction

  always @(posedge clk) cyc++;

  // Downstream ready: 0 = always ready, 1 = stalled, otherwise random.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'b0;
      default: out_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Monitor: every output transfer must match the oldest outstanding beat.
  always @(negedge clk) begin
    if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      rx++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got sum %0h, expected no beat", out_sum);
      end else begin
        me = sb.pop_front();
        check("sum", {16'h0, out_sum}, {16'h0, me.sum});
        check("flags_cout_ovf_zero", {29'h0, out_cout, out_ovf, out_zero},
              {29'h0, me.cout, me.ovf, me.zero});
        if (me.chk_lat) check("latency", cyc - me.acc_cyc, 3);
      end
      if (chk_gap && rx_window > 0) check("no_gap", cyc - last_arr, 1);
      rx_window++;
      last_arr = cyc;
    end
  end

  // Present one beat and hold it until accepted (bounded).
  task automatic send(input logic [15:0] a, input logic [15:0] b,
                      input logic sub, input exp_t e);
    int n;
    n = 0;
    in_a = a; in_b = b; in_sub = sub; in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 200) break;
    end
    if (in_ready) begin
      e.acc_cyc = cyc;
      sb.push_back(e);
      tx++;
    end else begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got in_ready 0 for %0d cycles, expected 1", n);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check(name, sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int   tx0;
    int   rx0;
    exp_t e;
    logic [15:0] ra, rb;
    logic        rs;

    // Hand-computed directed vectors.
    vecs[0]  = '{16'h1234, 16'h4321, 1'b0, mk(16'h5555, 1'b0, 1'b0, 1'b0)};
    vecs[1]  = '{16'h0005, 16'h0007, 1'b1, mk(16'hFFFE, 1'b0, 1'b0, 1'b0)};
    vecs[2]  = '{16'h0007, 16'h0005, 1'b1, mk(16'h0002, 1'b1, 1'b0, 1'b0)};
    vecs[3]  = '{16'hFFFF, 16'h0001, 1'b0, mk(16'h0000, 1'b1, 1'b0, 1'b1)};
    vecs[4]  = '{16'h7FFF, 16'h0001, 1'b0, mk(16'h8000, 1'b0, 1'b1, 1'b0)};
    vecs[5]  = '{16'h8000, 16'h0001, 1'b1, mk(16'h7FFF, 1'b1, 1'b1, 1'b0)};
    // Backpressure burst.
    vecs[6]  = '{16'h0001, 16'h0001, 1'b0, mk(16'h0002, 1'b0, 1'b0, 1'b0)};
    vecs[7]  = '{16'h0010, 16'h0020, 1'b0, mk(16'h0030, 1'b0, 1'b0, 1'b0)};
    vecs[8]  = '{16'h0100, 16'h0001, 1'b1, mk(16'h00FF, 1'b1, 1'b0, 1'b0)};
    vecs[9]  = '{16'hAAAA, 16'h5555, 1'b0, mk(16'hFFFF, 1'b0, 1'b0, 1'b0)};
    vecs[10] = '{16'h8000, 16'h8000, 1'b0, mk(16'h0000, 1'b1, 1'b1, 1'b1)};
    vecs[11] = '{16'h0003, 16'h0003, 1'b1, mk(16'h0000, 1'b1, 1'b0, 1'b1)};

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", {31'h0, out_valid}, 0);
    check("reset_out_sum", {16'h0, out_sum}, 0);
    check("reset_flags", {29'h0, out_cout, out_ovf, out_zero}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("in_ready_after_reset", {31'h0, in_ready}, 1);

    // 1: plain add with latency measured from an empty pipe.
    e = vecs[0].e;
    e.chk_lat = 1'b1;
    send(vecs[0].a, vecs[0].b, vecs[0].sub, e);
    wait_drain("drain_add");

    // 2, 3: subtraction/borrow, wrap-around and overflow, back to back.
    for (int i = 1; i <= 5; i++) send(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].e);
    wait_drain("drain_sub_wrap");

    // 4: backpressure. The pipe holds three beats, then in_ready drops.
    tx0 = tx;
    rx0 = rx;
    rdy_mode = 1;
    @(posedge clk);
    #1;
    fork
      begin
        for (int i = 6; i <= 11; i++) send(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].e);
      end
      begin
        repeat (15) @(negedge clk);
        check("bp_accepts", tx - tx0, 3);
        check("bp_in_ready", {31'h0, in_ready}, 0);
        check("bp_no_output", rx - rx0, 0);
        rx_window = 0;
        chk_gap = 1'b1;
        rdy_mode = 0;
      end
    join
    wait_drain("drain_bp");
    chk_gap = 1'b0;
    check("bp_count", rx - rx0, 6);

    // 5: reset with two beats in flight.
    send(16'h1111, 16'h2222, 1'b0, mk(16'h3333, 1'b0, 1'b0, 1'b0));
    send(16'h4444, 16'h1111, 1'b1, mk(16'h3333, 1'b1, 1'b0, 1'b0));
    #1;
    rst = 1'b1;
    #1;
    check("midreset_out_valid", {31'h0, out_valid}, 0);
    check("midreset_out_sum", {16'h0, out_sum}, 0);
    sb.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    rx0 = rx;
    repeat (10) @(negedge clk);
    check("no_stale_beat", rx - rx0, 0);
    check("in_ready_after_midreset", {31'h0, in_ready}, 1);
    @(posedge clk);
    #1;

    // 6: random traffic against the arithmetic model.
    tx0 = tx;
    rx0 = rx;
    rdy_mode = 2;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      ra = 16'($urandom);
      rb = 16'($urandom);
      rs = 1'($urandom_range(0, 1));
      send(ra, rb, rs, model(ra, rb, rs));
    end
    rdy_mode = 0;
    wait_drain("drain_random");
    check("random_count", rx - rx0, tx - tx0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
